// File: rtl/kernel_seidel_2d_pkg.sv
// Shared types and constants for the seidel-2d address generator.
// No logic, so no latency of its own.
// No backpressure of its own; the users of these types apply stall handling.
package kernel_seidel_2d_pkg;

    localparam int I_W         = 10;
    localparam int N_W         = 11;
    localparam int ADDR_W      = 20;
    localparam int T_W         = 8;

    localparam int N_DEF       = 1000;
    localparam int TSTEPS_DEF  = 20;
    localparam int MUL_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One issued iteration. It travels alongside its product through the multiplier.
    typedef struct packed {
        logic           vld;
        logic [I_W-1:0] j;
        logic [T_W-1:0] t;
        logic           last;
    } tag_t;

endpackage

// File: rtl/seidel_2d_loop_ctr.sv
// t/i/j loop nest for the stencil sweep, with j innermost and i/j running 1..N-2.
// The counters step one iteration per cycle when step_i is high.
// Holding step_i low freezes the nest, so a stall loses no iteration.
module seidel_2d_loop_ctr
    import kernel_seidel_2d_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int TSTEPS = TSTEPS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr_i,
    input  logic           step_i,
    output logic [I_W-1:0] i_o,
    output logic [I_W-1:0] j_o,
    output logic [T_W-1:0] t_o,
    output logic           last_o
);

    localparam logic [I_W-1:0] IJ_MAX = (N > 2) ? I_W'(N - 2) : I_W'(1);
    localparam logic [T_W-1:0] T_MAX  = (TSTEPS > 0) ? T_W'(TSTEPS - 1) : '0;

    logic [I_W-1:0] i_q, i_d, j_q, j_d;
    logic [T_W-1:0] t_q, t_d;
    logic           j_wrap, i_wrap, t_wrap;

    assign j_wrap = (j_q == IJ_MAX);
    assign i_wrap = (i_q == IJ_MAX);
    assign t_wrap = (t_q == T_MAX);

    // Advance the nest. A full wrap returns to (0,1,1), so the next sweep starts clean.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        t_d = t_q;
        if (step_i) begin
            if (j_wrap) begin
                j_d = I_W'(1);
                if (i_wrap) begin
                    i_d = I_W'(1);
                    t_d = t_wrap ? '0 : t_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            i_q <= I_W'(1);
            j_q <= I_W'(1);
            t_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            t_q <= t_d;
        end
    end

    assign i_o    = i_q;
    assign j_o    = j_q;
    assign t_o    = t_q;
    assign last_o = j_wrap & i_wrap & t_wrap;

endmodule

// File: rtl/kernel_seidel_2d_addr_gen.sv
// Drives the i*N multiplier and emits centre-cell addresses i*N+j (optional SEIDEL_ADDR_NEIGH_EN: also the N/S neighbours).
// The first addr_valid appears MUL_LAT+1 cycles after start; after that, one address per cycle.
// When addr_valid is high and addr_ready is low, mul_ce drops, which freezes the counters, the tags and the multiplier.
module kernel_seidel_2d_addr_gen
    import kernel_seidel_2d_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TSTEPS  = TSTEPS_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [I_W-1:0]    mul_a,
    output logic [N_W-1:0]    mul_b,
    output logic              mul_ce,
    input  logic [ADDR_W-1:0] mul_p,
    output logic [ADDR_W-1:0] addr_o,
    output logic [T_W-1:0]    t_o,
    output logic              last_o,
    output logic              addr_valid,
    input  logic              addr_ready
`ifdef SEIDEL_ADDR_NEIGH_EN
    ,
    output logic [ADDR_W-1:0] addr_n_o,
    output logic [ADDR_W-1:0] addr_s_o
`endif
);

    // A sweep with no interior cells or no time steps produces no words.
    localparam bit HAS_WORK = (TSTEPS > 0) && (N >= 3);

    state_t         state_q, state_d;
    logic           issue;
    logic [I_W-1:0] ctr_i, ctr_j;
    logic [T_W-1:0] ctr_t;
    logic           ctr_last;
    logic [I_W-1:0] mul_a_q;
    tag_t           iss_q;
    tag_t           dl_q [MUL_LAT];
    tag_t           tail;

    assign tail   = dl_q[MUL_LAT-1];
    assign mul_ce = ~(addr_valid & ~addr_ready);

    // The first iteration issues on the same edge that accepts start.
    assign issue = mul_ce & ((state_q == ST_RUN) |
                             ((state_q == ST_IDLE) & start & HAS_WORK));

    seidel_2d_loop_ctr #(
        .N      (N),
        .TSTEPS (TSTEPS)
    ) u_loop_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q == ST_DONE),
        .step_i (issue),
        .i_o    (ctr_i),
        .j_o    (ctr_j),
        .t_o    (ctr_t),
        .last_o (ctr_last)
    );

    // Sweep FSM: next state plus the busy/done flags.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!HAS_WORK) begin
                        state_d = ST_DONE;
                    end else if (ctr_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (issue && ctr_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (addr_valid && addr_ready && last_o) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue stage: i goes to the multiplier while its tag enters the tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a_q <= '0;
            iss_q   <= '0;
        end else if (mul_ce) begin
            if (issue) begin
                mul_a_q <= ctr_i;
                iss_q   <= '{vld: 1'b1, j: ctr_j, t: ctr_t, last: ctr_last};
            end else begin
                iss_q   <= '0;
            end
        end
    end

    // Tag delay line: MUL_LAT deep, so the tail lines up with mul_p.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                dl_q[k] <= '0;
            end
        end else if (mul_ce) begin
            dl_q[0] <= iss_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                dl_q[k] <= dl_q[k-1];
            end
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = N_W'(N);
    assign addr_valid = tail.vld;
    assign t_o        = tail.t;
    assign last_o     = tail.vld & tail.last;
    // Gate with valid so stale products never show on the bus.
    assign addr_o     = tail.vld ? (mul_p + ADDR_W'(tail.j)) : '0;

`ifdef SEIDEL_ADDR_NEIGH_EN
    assign addr_n_o   = tail.vld ? (addr_o - ADDR_W'(N)) : '0;
    assign addr_s_o   = tail.vld ? (addr_o + ADDR_W'(N)) : '0;
`endif

endmodule
